// File: rtl/led_pkg.sv
// Shared types for the LED pattern generator: config modes, channel FSM states,
// and the channel-select width helper.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE,
      SOLID,
      PH_ON,
      PH_OFF
   } chan_st_e;

   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: mode FSM, phase timer counted in prescaler ticks, burst
// counter and the registered burst-done pulse.
module led_chan
   import led_pkg::*;
#(
   parameter int RATE_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              wr,
   input  mode_e             mode,
   input  logic [RATE_W-1:0] rate,
   input  logic [CNT_W-1:0]  cnt,
   output logic              lit,
   output logic              done
);

   localparam logic [RATE_W:0] PH_ONE = 1;

   chan_st_e          state_q, state_d;
   logic [RATE_W-1:0] rate_q, rate_d;
   logic [RATE_W-1:0] ph_q, ph_d;
   logic [CNT_W-1:0]  burst_q, burst_d;
   logic              is_burst_q, is_burst_d;
   logic              done_q, done_d;
   logic [RATE_W-1:0] eff_rate;
   logic [RATE_W:0]   ph_inc;
   logic              timing;

   assign eff_rate = (rate_q == '0) ? RATE_W'(1) : rate_q;
   assign ph_inc   = {1'b0, ph_q} + PH_ONE;
   assign timing   = (state_q == PH_ON) || (state_q == PH_OFF);

   always_comb begin
      state_d    = state_q;
      rate_d     = rate_q;
      ph_d       = ph_q;
      burst_d    = burst_q;
      is_burst_d = is_burst_q;
      done_d     = 1'b0;
      // A write takes priority over a coincident tick, which is simply dropped.
      if (wr) begin
         rate_d     = rate;
         burst_d    = cnt;
         is_burst_d = (mode == MODE_BURST);
         ph_d       = '0;
         case (mode)
            MODE_OFF:   state_d = IDLE;
            MODE_ON:    state_d = SOLID;
            MODE_BLINK: state_d = PH_ON;
            MODE_BURST: begin
               if (cnt == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = PH_ON;
               end
            end
         endcase
      end else if (tick && timing) begin
         if (ph_inc == {1'b0, eff_rate}) begin
            ph_d = '0;
            if (state_q == PH_ON) begin
               state_d = PH_OFF;
            end else if (is_burst_q && (burst_q == CNT_W'(1))) begin
               state_d = IDLE;
               burst_d = '0;
               done_d  = 1'b1;
            end else begin
               state_d = PH_ON;
               if (is_burst_q) burst_d = burst_q - CNT_W'(1);
            end
         end else begin
            ph_d = ph_inc[RATE_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         rate_q     <= '0;
         ph_q       <= '0;
         burst_q    <= '0;
         is_burst_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rate_q     <= rate_d;
         ph_q       <= ph_d;
         burst_q    <= burst_d;
         is_burst_q <= is_burst_d;
         done_q     <= done_d;
      end
   end

   assign lit  = (state_q == SOLID) || (state_q == PH_ON);
   assign done = done_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared tick prescaler, per-channel FSMs
// and registered polarity-corrected prled. Define LED_PWM_EN for per-channel duty dimming.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int  NUM_LED        = 4,
   parameter int  TICK_DIV       = 10000,
   parameter int  RATE_W         = 8,
   parameter int  CNT_W          = 4,
   parameter bit  LED_ACTIVE_LOW = 1'b1,
   localparam int CH_W           = ch_w(NUM_LED)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_we,
   input  logic [CH_W-1:0]    cfg_ch,
   input  logic [1:0]         cfg_mode,
   input  logic [RATE_W-1:0]  cfg_rate,
   input  logic [CNT_W-1:0]   cfg_cnt,
`ifdef LED_PWM_EN
   input  logic [3:0]         cfg_duty,
`endif
   output logic [NUM_LED-1:0] done,
   output logic [NUM_LED-1:0] prled
);

   localparam int PW = $clog2(TICK_DIV);

   logic [PW-1:0]      presc_q, presc_d;
   logic               tick;
   logic [NUM_LED-1:0] wr, lit, on;
   logic [NUM_LED-1:0] prled_q, prled_d;

   assign tick    = (presc_q == PW'(TICK_DIV - 1));
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   // Out-of-range channel numbers match no instance, so those writes vanish.
   for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_chan
      assign wr[gi] = cfg_we && (cfg_ch == CH_W'(gi));
      led_chan #(
         .RATE_W (RATE_W),
         .CNT_W  (CNT_W)
      ) u_chan (
         .clk  (clk),
         .rst  (rst),
         .tick (tick),
         .wr   (wr[gi]),
         .mode (mode_e'(cfg_mode)),
         .rate (cfg_rate),
         .cnt  (cfg_cnt),
         .lit  (lit[gi]),
         .done (done[gi])
      );
   end

`ifdef LED_PWM_EN
   logic [3:0]              pwm_cnt_q, pwm_cnt_d;
   logic [NUM_LED-1:0][3:0] duty_q, duty_d;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 4'd1;
      duty_d    = duty_q;
      on        = '0;
      for (int i = 0; i < NUM_LED; i++) begin
         if (wr[i]) duty_d[i] = cfg_duty;
         on[i] = lit[i] && (pwm_cnt_q <= duty_q[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         duty_q    <= {NUM_LED{4'd15}};
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         duty_q    <= duty_d;
      end
   end
`else
   assign on = lit;
`endif

   assign prled_d = LED_ACTIVE_LOW ? ~on : on;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= '0;
         prled_q <= {NUM_LED{LED_ACTIVE_LOW}};
      end else begin
         presc_q <= presc_d;
         prled_q <= prled_d;
      end
   end

   assign prled = prled_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: a tick-counting behavioural model checked every
// cycle, directed scenarios with literal timing expectations, then random writes.
module tb_led_pattern_gen;

   localparam int NL = 4;
   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_ch = '0;
   logic [1:0] cfg_mode = '0;
   logic [7:0] cfg_rate = '0;
   logic [3:0] cfg_cnt = '0;
`ifdef LED_PWM_EN
   logic [3:0] cfg_duty = 4'd15;
`endif
   logic [3:0] done, prled;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_pattern_gen #(
      .NUM_LED(NL), .TICK_DIV(TD), .RATE_W(8), .CNT_W(4), .LED_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
      .cfg_rate(cfg_rate), .cfg_cnt(cfg_cnt),
`ifdef LED_PWM_EN
      .cfg_duty(cfg_duty),
`endif
      .done(done), .prled(prled)
   );

   // Model: per channel the mode and the number of ticks counted since the
   // last write; lit-ness follows from (ticks / rate) parity.
   int         m_presc, m_pwm;
   int         m_mode[NL], m_rate[NL], m_cnt[NL], m_ticks[NL], m_duty[NL];
   logic [3:0] exp_prled, exp_done;

   function automatic logic m_lit(input int i);
      int r;
      r = (m_rate[i] == 0) ? 1 : m_rate[i];
      if (m_mode[i] == 0) return 1'b0;
      if (m_mode[i] == 1) return 1'b1;
      return ((m_ticks[i] / r) % 2) == 0;
   endfunction

   task automatic model_reset();
      m_presc = 0;
      m_pwm   = 0;
      for (int i = 0; i < NL; i++) begin
         m_mode[i] = 0; m_rate[i] = 0; m_cnt[i] = 0; m_ticks[i] = 0; m_duty[i] = 15;
      end
      exp_prled = 4'hF;
      exp_done  = 4'h0;
   endtask

   task automatic model_edge();
      logic tick;
      int   r;
      tick = (m_presc == TD - 1);
      for (int i = 0; i < NL; i++) begin
         logic l;
         l = m_lit(i);
`ifdef LED_PWM_EN
         l = l && (m_pwm <= m_duty[i]);
`endif
         exp_prled[i] = ~l;
      end
      exp_done = 4'h0;
      for (int i = 0; i < NL; i++) begin
         if (cfg_we && (int'(cfg_ch) == i)) begin
            m_mode[i]  = int'(cfg_mode);
            m_rate[i]  = int'(cfg_rate);
            m_cnt[i]   = int'(cfg_cnt);
            m_ticks[i] = 0;
`ifdef LED_PWM_EN
            m_duty[i]  = int'(cfg_duty);
`endif
            if (m_mode[i] == 3 && m_cnt[i] == 0) begin
               exp_done[i] = 1'b1;
               m_mode[i]   = 0;
            end
         end else if (tick && m_mode[i] >= 2) begin
            r = (m_rate[i] == 0) ? 1 : m_rate[i];
            m_ticks[i]++;
            if (m_mode[i] == 3 && m_ticks[i] == 2 * m_cnt[i] * r) begin
               exp_done[i] = 1'b1;
               m_mode[i]   = 0;
            end
         end
      end
      m_presc = tick ? 0 : m_presc + 1;
      m_pwm   = (m_pwm + 1) % 16;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
      end
   endtask

   task automatic check_rng(input string name, input int got, input int lo, input int hi);
      checks++;
      if (got < lo || got > hi) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d..%0d", name, $time, got, lo, hi);
      end
   endtask

   task automatic compare();
      check("prled", 32'(prled), 32'(exp_prled));
      check("done", 32'(done), 32'(exp_done));
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      cfg_we = 1'b0;
      compare();
   endtask

   task automatic wr(input int ch, input int mode, input int rate, input int cnt);
      cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_mode = 2'(mode);
      cfg_rate = 8'(rate); cfg_cnt = 4'(cnt);
      step();
   endtask

   task automatic align();
      int g = 0;
      while (m_presc != TD - 1 && g < 2 * TD) begin
         step();
         g++;
      end
   endtask

   task automatic run_len(input int ch, input logic val, input int lim, output int n);
      n = 0;
      while (prled[ch] === val && n < lim) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n, dc, lows;
      logic v;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      compare();
      check("reset_prled", 32'(prled), 32'hF);

      // ON: visible one edge after the write edge
      wr(2, 1, 0, 0);
      check("on_lat", 32'(prled), 32'hF);
      step();
      check("on", 32'(prled), 32'b1011);

      // BLINK rate 3, arbitrary prescaler alignment
      wr(0, 2, 3, 0);
      step();
      check("blink_lit", 32'(prled[0]), 0);
      run_len(0, 1'b0, 40, n);
      check_rng("blink_first", n, 9, 12);
      for (int k = 0; k < 5; k++) begin
         v = prled[0];
         run_len(0, v, 40, n);
         check("blink_half", n, 12);
      end

      // asynchronous reset between edges
      step();
      #2 rst = 1'b1;
      #1;
      check("async_prled", 32'(prled), 32'hF);
      check("async_done", 32'(done), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      compare();
      repeat (8) step();
      check("post_reset_idle", 32'(prled), 32'hF);

      // BURST rate 1 cnt 2, written on a tick edge
      align();
      wr(1, 3, 1, 2);
      step();
      check("burst_lit", 32'(prled[1]), 0);
      run_len(1, 1'b0, 20, n);
      check("burst_low1", n, 4);
      run_len(1, 1'b1, 20, n);
      check("burst_gap", n, 4);
      run_len(1, 1'b0, 20, n);
      check("burst_low2", n, 4);
      dc = 0; lows = 0;
      repeat (12) begin
         step();
         dc += int'(done[1]);
         lows += int'(!prled[1]);
      end
      check("burst_done_cnt", dc, 1);
      check("burst_dark", lows, 0);

      // BURST cnt 0
      wr(1, 3, 1, 0);
      check("cnt0_done", 32'(done[1]), 1);
      check("cnt0_dark", 32'(prled[1]), 1);
      step();
      check("cnt0_done_end", 32'(done[1]), 0);
      check("cnt0_dark2", 32'(prled[1]), 1);

      // write colliding with a tick: that tick is not counted
      align();
      wr(3, 2, 3, 0);
      step();
      check("collide_lit", 32'(prled[3]), 0);
      run_len(3, 1'b0, 40, n);
      check("collide_first", n, 12);

      // abort mid-burst with OFF
      wr(1, 3, 2, 3);
      repeat (10) step();
      wr(1, 0, 0, 0);
      dc = 0;
      repeat (60) begin
         step();
         dc += int'(done[1]);
      end
      check("abort_no_done", dc, 0);
      check("abort_dark", 32'(prled[1]), 1);

`ifdef LED_PWM_EN
      cfg_duty = 4'd3;
      wr(0, 1, 0, 0);
      step();
      lows = 0;
      repeat (16) begin
         step();
         lows += int'(!prled[0]);
      end
      check("pwm_duty3", lows, 4);
      cfg_duty = 4'd15;
      wr(0, 1, 0, 0);
      step();
      lows = 0;
      repeat (16) begin
         step();
         lows += int'(!prled[0]);
      end
      check("pwm_duty15", lows, 16);
`endif

      // random writes, model checked every cycle
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(5) == 0) begin
            cfg_we   = 1'b1;
            cfg_ch   = 2'($urandom_range(3));
            cfg_mode = 2'($urandom_range(3));
            cfg_rate = 8'($urandom_range(4));
            cfg_cnt  = 4'($urandom_range(3));
`ifdef LED_PWM_EN
            cfg_duty = 4'($urandom_range(15));
`endif
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised successor to the board's single-rate LED blinker. Drives NUM_LED front-panel LEDs. Each channel is independently configured through a one-cycle write strobe to one of four modes: OFF, ON, continuous BLINK, or counted BURST. A shared prescaler generates a tick, and each per-channel FSM times its on/off phases in ticks. Sits at top level between the config/control logic and the prled pins.

Parameters:
NUM_LED, 4, number of LED channels (1..16)
TICK_DIV, 10000, clk cycles per tick (1 kHz at 10 MHz clk); minimum 2
RATE_W, 8, width of per-channel half-period (in ticks)
CNT_W, 4, width of burst flash count
LED_ACTIVE_LOW, 1, 1 = prled driven low to light

Ports:
clk  in  1  system clock; the block's only clock
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  one-cycle config write strobe
cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_LED))
cfg_mode  in  2  0 OFF, 1 ON, 2 BLINK, 3 BURST
cfg_rate  in  RATE_W  half-period in ticks; 0 treated as 1
cfg_cnt  in  CNT_W  flashes for BURST
done  out  NUM_LED  one-cycle pulse per channel when a burst completes
prled  out  NUM_LED  LED pins, polarity set by LED_ACTIVE_LOW

Behaviour:
- Reset (asynchronous, immediate): all channels IDLE; prled = all inactive ({NUM_LED{LED_ACTIVE_LOW}}); done = 0; prescaler = 0; phase/burst counters = 0.
- Prescaler: free-running 0..TICK_DIV-1. tick is an internal 1-cycle pulse when count == TICK_DIV-1. Config writes never reset the prescaler.
- Write: when cfg_we = 1 and cfg_ch < NUM_LED, the channel latches mode/rate/cnt on that edge. The new LED state appears on prled at the next edge (1-cycle latency). Writes with cfg_ch >= NUM_LED are ignored.
- Per-channel FSM states: IDLE (dark), SOLID (lit), PH_ON (lit), PH_OFF (dark).
  - OFF write -> IDLE.
  - ON write -> SOLID.
  - BLINK or BURST write -> PH_ON, phase counter = 0.
  - In PH_ON/PH_OFF, each tick increments the phase counter. When it reaches max(rate,1), the counter clears and the state toggles. The first toggle therefore occurs rate-1 to rate tick periods after the write.
  - BLINK: toggles PH_ON <-> PH_OFF indefinitely.
  - BURST: the burst counter is loaded with cfg_cnt and decremented at each PH_OFF -> PH_ON transition.
    - When PH_OFF expires with counter == 1: go to IDLE and pulse done[ch] for exactly one cycle.
    - cfg_cnt == 0: go straight to IDLE, done[ch] pulses on the cycle after the write, and the LED is never lit.
- Simultaneous write and tick on the same channel: the write wins and that tick is not counted.
- A rewrite mid-burst aborts the burst without a done pulse.
- rst asserted mid-operation: immediate return to reset values; no done pulse.
- prled is registered; no combinational path from cfg_* to prled.

Optional Feature:
LED_PWM_EN
- Defined:
  - adds input cfg_duty[3:0], latched on write, reset value 15;
  - adds a free-running 4-bit pwm_cnt on clk;
  - lit states are lit only when pwm_cnt <= duty (duty 15 = full, 0 = 1/16 brightness);
  - the PWM gating is inside the prled output register, so latency is unchanged.
- Undefined: no cfg_duty port; lit states are fully lit.

Decomposition:
- Package led_pkg holds:
  - the 2-bit mode typedef with MODE_OFF/ON/BLINK/BURST constants;
  - the channel state enum (IDLE, SOLID, PH_ON, PH_OFF);
  - a CH_W helper function.
- Sub-module led_chan implements one channel FSM (phase counter, burst counter, done, lit flag). It is instantiated NUM_LED times by generate.
- Prescaler, PWM counter and output polarity/register stay in led_pattern_gen.

Test Plan:
All scenarios use TICK_DIV=4, NUM_LED=4, LED_ACTIVE_LOW=1.
- Reset: assert rst mid-BLINK on ch0 -> prled=4'b1111 and done=0 asynchronously, before the next clk edge; all modes stay IDLE after release.
- ON: write ch2 mode 1 -> prled=4'b1011 one cycle later; other channels unaffected.
- BLINK: write ch0 mode 2 rate 3 -> prled[0]=0 next cycle, first toggle 9..12 clocks after write, then toggles every 12 clocks for at least 5 periods.
- BURST: write ch1 mode 3 rate 1 cnt 2 -> exactly two low phases of 4 clocks each, then done[1]=1 for one cycle and prled[1] stays 1; cnt 0 -> done[1] pulses the cycle after the write with no low phase.
- Collision/abort: write ch3 on a tick cycle -> phase count starts at 0 (first toggle 9..12 clocks later); rewrite ch1 mid-burst with OFF -> no done pulse.
- PWM (LED_PWM_EN): ch0 ON with duty 3 -> prled[0] low exactly 4 of every 16 clocks; duty 15 -> continuously low.
